// File: rtl/pi_seq_pkg.sv
// Shared definitions for the PI lock sequencer: state codes, gain width,
// KI ramp offset and relock counter width, plus the KI ramp start helper.
package pi_seq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_ACQUIRE = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;

  localparam int GAIN_W         = 8;
  localparam int KI_RAMP_OFFSET = 4;
  localparam int RELOCK_W       = 16;

  localparam logic signed [GAIN_W:0] KI_MIN = -(2 ** (GAIN_W - 1));

  // Starting KI for the gain ramp: target minus the offset, clamped at the
  // most negative shift code so a low target never wraps positive.
  function automatic logic signed [GAIN_W-1:0] ki_ramp_start(input logic signed [GAIN_W-1:0] k);
    logic signed [GAIN_W:0] t;
    t = {k[GAIN_W-1], k} - (GAIN_W+1)'(KI_RAMP_OFFSET);
    if (t < KI_MIN) return KI_MIN[GAIN_W-1:0];
    return t[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/pi_abs_window.sv
// Signed magnitude compared against an unsigned limit. The magnitude is one
// bit wider than the input so the most negative code maps to 2^(WIDTH-1).
module pi_abs_window #(
  parameter int WIDTH = 14,
  parameter int LIM_W = WIDTH
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic [LIM_W-1:0]        limit,
  output logic                    le,
  output logic                    ge
);

  logic signed [WIDTH:0] xe;
  logic [WIDTH:0]        mag;
  logic [WIDTH:0]        lim;

  assign xe  = {x[WIDTH-1], x};
  assign mag = x[WIDTH-1] ? $unsigned(-xe) : $unsigned(xe);
  assign lim = {{(WIDTH + 1 - LIM_W){1'b0}}, limit};
  assign le  = (mag <= lim);
  assign ge  = (mag >= lim);

endmodule

// File: rtl/pi_lock_sequencer.sv
// Lock-acquisition sequencer for the phasemeter PI servo: IDLE -> SETTLE
// (PI held in reset) -> ACQUIRE (count in-band errors) -> LOCKED (count
// out-of-band errors). Config is snapshotted on every SETTLE entry.
// Optional feature macro: PI_SEQ_GAIN_RAMP_EN (ramps KI up to its target in
// ACQUIRE and holds lock counting until the ramp completes).
module pi_lock_sequencer
  import pi_seq_pkg::*;
#(
  parameter int ERR_WIDTH = 14,
  parameter int ACT_WIDTH = 32,
  parameter int CNT_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [GAIN_W-1:0]    cfg_kp,
  input  logic signed [GAIN_W-1:0]    cfg_ki,
  input  logic signed [GAIN_W-1:0]    cfg_kg,
  input  logic                        cfg_kg_sign,
  input  logic [ERR_WIDTH-1:0]        cfg_lock_thresh,
  input  logic [CNT_WIDTH-1:0]        cfg_lock_cycles,
  input  logic [CNT_WIDTH-1:0]        cfg_unlock_cycles,
  input  logic [CNT_WIDTH-1:0]        cfg_settle_cycles,
  input  logic [ACT_WIDTH-2:0]        cfg_rail,
  input  logic signed [ERR_WIDTH-1:0] err,
  input  logic                        err_valid,
  input  logic signed [ACT_WIDTH-1:0] action,
  output logic                        pi_rst,
  output logic signed [GAIN_W-1:0]    kp,
  output logic signed [GAIN_W-1:0]    ki,
  output logic signed [GAIN_W-1:0]    kg,
  output logic                        kg_sign,
  output logic                        locked,
  output logic [2:0]                  state,
  output logic [RELOCK_W-1:0]         relock_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [2:0]              nxt;
  logic [CNT_WIDTH-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [CNT_WIDTH-1:0]    lat_settle, lat_lock, lat_unlock;
  logic [ERR_WIDTH-1:0]    lat_thresh;
  logic [ACT_WIDTH-2:0]    lat_rail;
  logic                    in_band, rail_ge, err_ge_unused, act_le_unused;
  logic                    count_en, enter_settle;
  logic                    pi_rst_d, locked_d;
  logic signed [GAIN_W-1:0] ki_d;
  logic [RELOCK_W-1:0]     relock_d;

  function automatic logic [CNT_WIDTH-1:0] at_least_one(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

  pi_abs_window #(.WIDTH(ERR_WIDTH), .LIM_W(ERR_WIDTH)) u_err_win (
    .x(err), .limit(lat_thresh), .le(in_band), .ge(err_ge_unused)
  );

  pi_abs_window #(.WIDTH(ACT_WIDTH), .LIM_W(ACT_WIDTH - 1)) u_rail_win (
    .x(action), .limit(lat_rail), .le(act_le_unused), .ge(rail_ge)
  );

  assign cnt_inc      = cnt + CNT_ONE;
  assign enter_settle = (nxt == ST_SETTLE) && (state != ST_SETTLE);

`ifdef PI_SEQ_GAIN_RAMP_EN
  logic [CNT_WIDTH-1:0]     rtmr, rtmr_d, rtmr_inc;
  logic signed [GAIN_W-1:0] lat_ki;
  assign rtmr_inc = rtmr + CNT_ONE;
  assign count_en = (ki == lat_ki);
`else
  assign count_en = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state and shared sample/settle counter
  always_comb begin
    nxt     = state;
    cnt_nxt = '0;
    case (state)
      ST_IDLE: if (enable) nxt = ST_SETTLE;
      ST_SETTLE: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == at_least_one(lat_settle)) nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        cnt_nxt = cnt;
        if (!count_en)      cnt_nxt = '0;
        else if (err_valid) cnt_nxt = in_band ? cnt_inc : '0;
        if (rail_ge) nxt = ST_SETTLE;
        else if (count_en && err_valid && in_band && cnt_inc == at_least_one(lat_lock))
          nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        cnt_nxt = cnt;
        if (err_valid) cnt_nxt = in_band ? '0 : cnt_inc;
        if (rail_ge) nxt = ST_SETTLE;
        else if (err_valid && !in_band && cnt_inc == at_least_one(lat_unlock))
          nxt = ST_SETTLE;
      end
      default: nxt = ST_IDLE;
    endcase
    if (!enable) nxt = ST_IDLE;
    if (nxt != state) cnt_nxt = '0;
  end

  // Next values of the registered outputs
  always_comb begin
    pi_rst_d = !((nxt == ST_ACQUIRE) || (nxt == ST_LOCKED));
    locked_d = (nxt == ST_LOCKED);
    relock_d = relock_count;
    if ((state == ST_ACQUIRE || state == ST_LOCKED) && nxt == ST_SETTLE && relock_count != '1)
      relock_d = relock_count + RELOCK_W'(1);
`ifdef PI_SEQ_GAIN_RAMP_EN
    ki_d   = ki;
    rtmr_d = rtmr;
    if (enter_settle) begin
      ki_d   = cfg_ki;
      rtmr_d = '0;
    end else if (state == ST_SETTLE && nxt == ST_ACQUIRE) begin
      ki_d   = ki_ramp_start(lat_ki);
      rtmr_d = '0;
    end else if (state == ST_ACQUIRE && nxt == ST_ACQUIRE && !count_en) begin
      if (rtmr_inc == at_least_one(lat_settle)) begin
        ki_d   = ki + GAIN_W'(1);
        rtmr_d = '0;
      end else begin
        rtmr_d = rtmr_inc;
      end
    end
`else
    ki_d = enter_settle ? cfg_ki : ki;
`endif
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      pi_rst       <= 1'b1;
      locked       <= 1'b0;
      ki           <= '0;
      relock_count <= '0;
`ifdef PI_SEQ_GAIN_RAMP_EN
      rtmr         <= '0;
`endif
    end else begin
      cnt          <= cnt_nxt;
      pi_rst       <= pi_rst_d;
      locked       <= locked_d;
      ki           <= ki_d;
      relock_count <= relock_d;
`ifdef PI_SEQ_GAIN_RAMP_EN
      rtmr         <= rtmr_d;
`endif
    end
  end

  // Config snapshot taken on every SETTLE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp         <= '0;
      kg         <= '0;
      kg_sign    <= 1'b0;
      lat_settle <= '0;
      lat_lock   <= '0;
      lat_unlock <= '0;
      lat_thresh <= '0;
      lat_rail   <= '0;
`ifdef PI_SEQ_GAIN_RAMP_EN
      lat_ki     <= '0;
`endif
    end else if (enter_settle) begin
      kp         <= cfg_kp;
      kg         <= cfg_kg;
      kg_sign    <= cfg_kg_sign;
      lat_settle <= cfg_settle_cycles;
      lat_lock   <= cfg_lock_cycles;
      lat_unlock <= cfg_unlock_cycles;
      lat_thresh <= cfg_lock_thresh;
      lat_rail   <= cfg_rail;
`ifdef PI_SEQ_GAIN_RAMP_EN
      lat_ki     <= cfg_ki;
`endif
    end
  end

endmodule

// File: tb/tb_pi_lock_sequencer.sv
// Bench for pi_lock_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pi_lock_sequencer;

  localparam int EW = 14;
  localparam int AW = 32;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic signed [7:0] cfg_kp, cfg_ki, cfg_kg;
  logic cfg_kg_sign;
  logic [EW-1:0] cfg_lock_thresh;
  logic [CW-1:0] cfg_lock_cycles, cfg_unlock_cycles, cfg_settle_cycles;
  logic [AW-2:0] cfg_rail;
  logic signed [EW-1:0] err;
  logic err_valid;
  logic signed [AW-1:0] action;
  logic pi_rst, kg_sign, locked;
  logic signed [7:0] kp, ki, kg;
  logic [2:0] state;
  logic [15:0] relock_count;

  pi_lock_sequencer #(.ERR_WIDTH(EW), .ACT_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_kg(cfg_kg), .cfg_kg_sign(cfg_kg_sign),
    .cfg_lock_thresh(cfg_lock_thresh), .cfg_lock_cycles(cfg_lock_cycles),
    .cfg_unlock_cycles(cfg_unlock_cycles), .cfg_settle_cycles(cfg_settle_cycles),
    .cfg_rail(cfg_rail), .err(err), .err_valid(err_valid), .action(action),
    .pi_rst(pi_rst), .kp(kp), .ki(ki), .kg(kg), .kg_sign(kg_sign),
    .locked(locked), .state(state), .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 settle, 2 acquire, 3 locked
  int m_mode, m_left, m_run, m_rtick, m_relock;
  int m_kp, m_ki, m_kg, m_sign;
  int s_ki, s_thresh, s_lock, s_unlock, s_settle;
  longint s_rail;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_left = 0; m_run = 0; m_rtick = 0; m_relock = 0;
    m_kp = 0; m_ki = 0; m_kg = 0; m_sign = 0;
    s_ki = 0; s_thresh = 0; s_lock = 0; s_unlock = 0; s_settle = 0; s_rail = 0;
  endtask

  task automatic m_enter_settle();
    m_kp = int'(cfg_kp); m_ki = int'(cfg_ki); m_kg = int'(cfg_kg); m_sign = int'(cfg_kg_sign);
    s_ki = int'(cfg_ki);
    s_thresh = int'(cfg_lock_thresh); s_lock = int'(cfg_lock_cycles);
    s_unlock = int'(cfg_unlock_cycles); s_settle = int'(cfg_settle_cycles);
    s_rail = longint'(cfg_rail);
    m_mode = 1; m_left = max1(s_settle); m_run = 0;
  endtask

  task automatic m_relock_settle();
    if (m_relock < 65535) m_relock++;
    m_enter_settle();
  endtask

  task automatic m_enter_acq();
    m_mode = 2; m_run = 0;
`ifdef PI_SEQ_GAIN_RAMP_EN
    m_ki = (s_ki - 4 < -128) ? -128 : s_ki - 4;
    m_rtick = 0;
`endif
  endtask

  task automatic m_step();
    int ae;
    longint aa;
    bit gate;
    ae = int'(err);
    if (ae < 0) ae = -ae;
    aa = longint'(action);
    if (aa < 0) aa = -aa;
    if (!enable) m_mode = 0;
    else begin
      case (m_mode)
        0: m_enter_settle();
        1: begin
          m_left--;
          if (m_left == 0) m_enter_acq();
        end
        2: begin
          if (aa >= s_rail) m_relock_settle();
          else begin
            gate = (m_ki == s_ki);
            if (err_valid && gate) m_run = (ae <= s_thresh) ? m_run + 1 : 0;
            if (m_run >= max1(s_lock)) begin
              m_mode = 3; m_run = 0;
            end else if (!gate) begin
              m_rtick++;
              if (m_rtick >= max1(s_settle)) begin m_ki++; m_rtick = 0; end
            end
          end
        end
        default: begin
          if (aa >= s_rail) m_relock_settle();
          else if (err_valid) begin
            m_run = (ae <= s_thresh) ? 0 : m_run + 1;
            if (m_run >= max1(s_unlock)) m_relock_settle();
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      if (int'(state) == m_mode && pi_rst == (m_mode <= 1) && locked == (m_mode == 3) &&
          int'(kp) == m_kp && int'(ki) == m_ki && int'(kg) == m_kg &&
          int'(kg_sign) == m_sign && int'(relock_count) == m_relock)
        n_pass++;
      else
        $display("FAIL model t=%0t: state %0d/%0d pi_rst %0b locked %0b kp %0d/%0d ki %0d/%0d kg %0d/%0d sign %0b/%0d relock %0d/%0d",
                 $time, state, m_mode, pi_rst, locked, kp, m_kp, ki, m_ki, kg, m_kg,
                 kg_sign, m_sign, relock_count, m_relock);
    end
  end

  // Wait for ACQUIRE with the gain (if ramped) at its target
  task automatic wait_acq_ready(input string nm);
    int k;
    k = 0;
    while (state != 3'd2 && k < 100) begin @(negedge clk); k++; end
`ifdef PI_SEQ_GAIN_RAMP_EN
    k = 0;
    while (ki != cfg_ki && state == 3'd2 && k < 100) begin @(negedge clk); k++; end
`endif
    chk(nm, state, 2);
  endtask

  initial begin
    int seq [9] = '{3, -8, 2, 9, 1, 1, 1, 1, 1};
    int cnt;
    m_reset();
    cfg_kp = 8'sd5; cfg_ki = -8'sd3; cfg_kg = 8'sd2; cfg_kg_sign = 1'b1;
    cfg_lock_thresh = 14'd8; cfg_lock_cycles = 24'd5; cfg_unlock_cycles = 24'd3;
    cfg_settle_cycles = 24'd10; cfg_rail = 31'd1000;
    err = '0; err_valid = 1'b0; action = '0;
    #1 rst = 1'b1;
    #1 mon_en = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0); chk("rst_pi_rst", pi_rst, 1);
    chk("rst_relock", relock_count, 0); chk("rst_kp", kp, 0);

    // settle length and gain snapshot
    rst = 1'b0; enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pi_rst) cnt++;
      if (state == 3'd2) break;
    end
    chk("settle_len", cnt, 10); chk("acq_state", state, 2); chk("acq_pi_rst", pi_rst, 0);
    chk("acq_kp", kp, 5); chk("acq_kg", kg, 2); chk("acq_sign", kg_sign, 1);
`ifdef PI_SEQ_GAIN_RAMP_EN
    chk("acq_ki", ki, -7);
`else
    chk("acq_ki", ki, -3);
`endif
    wait_acq_ready("acq_ready0");

    // lock run: the 9 on position 4 restarts the count
    err_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      err = EW'(seq[i]);
      @(negedge clk);
      if (i == 7) chk("no_lock_early", locked, 0);
    end
    chk("locked_rise", locked, 1); chk("locked_state", state, 3);

    // unlock after 3 out-of-band samples
    err = 14'sd100;
    repeat (2) @(negedge clk);
    chk("still_locked", state, 3);
    @(negedge clk);
    chk("unlock_state", state, 1); chk("unlock_relock", relock_count, 1);
    chk("unlock_pi_rst", pi_rst, 1);
    err_valid = 1'b0;

    // rail boundary; new thresholds latch at this SETTLE entry
    cfg_lock_thresh = 14'd8191; cfg_lock_cycles = 24'd1;
    wait_acq_ready("acq_ready1");
    action = -32'sd999;
    @(negedge clk); chk("rail_below", state, 2);
    action = -32'sd1000;
    @(negedge clk); chk("rail_hit", state, 1); chk("rail_relock", relock_count, 2);
    action = '0;

    // most negative error is out-of-band even with the widest window
    wait_acq_ready("acq_ready2");
    err = -14'sd8192; err_valid = 1'b1;
    @(negedge clk); chk("abs_most_neg", state, 2);
    err = 14'sd8191;
    @(negedge clk); chk("abs_edge_lock", state, 3);
    err_valid = 1'b0;

    // enable drop beats the lock-completing sample
    action = 32'sd2000;
    @(negedge clk); chk("rail_locked", state, 1); chk("rail_relock3", relock_count, 3);
    action = '0;
    wait_acq_ready("acq_ready3");
    err = '0; err_valid = 1'b1; enable = 1'b0;
    @(negedge clk); chk("en_vs_lock", state, 0); chk("en_vs_lock_lk", locked, 0);
    err_valid = 1'b0;

    // async reset mid-SETTLE
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_settle", state, 1);
    #2 rst = 1'b1;
    #1 chk("arst_state", state, 0); chk("arst_pi_rst", pi_rst, 1);
    chk("arst_relock", relock_count, 0); chk("arst_kp", kp, 0);
    @(negedge clk); rst = 1'b0;

`ifdef PI_SEQ_GAIN_RAMP_EN
    // KI ramp from a saturated start
    cfg_ki = -8'sd126; cfg_settle_cycles = 24'd3; cfg_lock_cycles = 24'd1;
    err = '0; err_valid = 1'b1;
    cnt = 0;
    while (state != 3'd2 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("ramp_start", ki, -128);
    cnt = 1;
    while (cnt < 50) begin @(negedge clk); if (state != 3'd2) break; cnt++; end
    chk("ramp_acq_len", cnt, 7); chk("ramp_ki_final", ki, -126); chk("ramp_locked", locked, 1);
    err_valid = 1'b0;
`endif

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        cfg_settle_cycles = CW'($urandom_range(0, 6));
        cfg_lock_cycles   = CW'($urandom_range(0, 6));
        cfg_unlock_cycles = CW'($urandom_range(0, 4));
        cfg_lock_thresh   = EW'($urandom_range(0, 40));
        cfg_rail          = (AW-1)'($urandom_range(100, 3000));
        cfg_kp = 8'($urandom); cfg_ki = 8'($urandom); cfg_kg = 8'($urandom);
        cfg_kg_sign = 1'($urandom);
      end
      enable = ($urandom_range(0, 99) != 0);
      err_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       err = EW'($urandom);
        1:       err = -14'sd8192;
        default: err = EW'(int'($urandom_range(0, 80)) - 40);
      endcase
      if ($urandom_range(0, 39) == 0) action = AW'($urandom);
      else action = AW'(int'($urandom_range(0, 1000)) - 500);
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
